// File: rtl/req_priority_arbiter.sv
// ---------------------------------------------------------------------------
// req_priority_arbiter
//
// Shares one downstream resource among 8 requesters. A winner is chosen by
// 8:1 priority selection, holds the grant until it pulses done, drops its
// request, or uses up its hold budget, and then the arbiter spends one dead
// cycle (RELEASE) before the next grant can appear.
//
// Index encoding: req[7] is index 0 (highest fixed priority), req[0] is
// index 7 (lowest).
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   undefined : fixed priority, req[7] always highest.
//   defined   : rotating priority. rr_ptr (index space) names the index that
//               is searched first; after every grant ends it moves to the
//               index just past the finished winner.
//
// Parameters:
//   MAX_HOLD  cycles a single grant may be held before forced release (1..255)
//   CNT_W     width of the hold counter, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, held high while wanting/owning the resource
//   done       one-cycle end-of-transaction pulse from the holder
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_idx    encoded index of the granted bit (bit 7 -> 0 ... bit 0 -> 7)
//   gnt_valid  high exactly when gnt is non-zero
//   timeout    one-cycle pulse when a grant is forcibly released
// ---------------------------------------------------------------------------
module req_priority_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [7:0]       req_idx;
    logic [2:0]       sel_idx;
    logic [7:0]       sel_onehot;
    logic             holder_req;
    logic             release_now;
    logic             hold_expired;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0]       rr_ptr;
`endif

    // Requests re-ordered into index space so that req_idx[0] is req[7].
    always_comb begin
        req_idx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            req_idx[i] = req[7 - i];
        end
    end

    // Winner selection. Loops run from the lowest priority slot upward so
    // that the last assignment made belongs to the highest priority request.
`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        logic [2:0] probe;
        sel_idx = 3'd0;
        probe   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            probe = rr_ptr + 3'(k);
            if (req_idx[probe]) begin
                sel_idx = probe;
            end
        end
    end
`else
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_idx[i]) begin
                sel_idx = 3'(i);
            end
        end
    end
`endif

    assign sel_onehot = 8'b1000_0000 >> sel_idx;

    // The holder's own request bit, found through the registered index.
    assign holder_req   = req[3'd7 - gnt_idx];
    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign release_now  = done || !holder_req || hold_expired;

    // Single state machine with registered outputs. timeout is a default-low
    // pulse that is only raised when the hold budget alone ends the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= 3'd0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (|req) begin
                        gnt       <= sel_onehot;
                        gnt_idx   <= sel_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end else begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    if (release_now) begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        timeout   <= !done && holder_req;
                        state     <= RELEASE;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_ptr    <= gnt_idx + 3'd1;
`endif
                    end
                end
                default: begin
                    gnt       <= 8'h00;
                    gnt_idx   <= 3'd0;
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_priority_arbiter
//
// Self-checking bench for req_priority_arbiter, built with MAX_HOLD=4 so that
// forced release is reached quickly. Each stimulus cycle pushes the expected
// outputs for the following clock edge onto a queue; after the edge the entry
// is popped and compared against the DUT. Expected grants are written out by
// hand for every sequence; the index/valid expectations are derived from the
// expected grant vector.
// ---------------------------------------------------------------------------
module tb_req_priority_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        string      tag;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [7:0] ALT_GNT = 8'h01;
`else
    localparam logic [7:0] ALT_GNT = 8'h80;
`endif

    req_priority_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Bit 7 encodes to 0, bit 0 encodes to 7; zero vector encodes to 0.
    function automatic logic [2:0] idxOf(input logic [7:0] g);
        for (int i = 7; i >= 0; i--) begin
            if (g[i]) return 3'(7 - i);
        end
        return 3'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".gnt"},       32'(gnt),       32'h0);
        checkOutput({tag, ".gnt_idx"},   32'(gnt_idx),   32'h0);
        checkOutput({tag, ".gnt_valid"}, 32'(gnt_valid), 32'h0);
        checkOutput({tag, ".timeout"},   32'(timeout),   32'h0);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next
    // edge, then take the edge and score the DUT against the queue head.
    task automatic applyStimulus(input string tag, input logic [7:0] r, input logic d,
                                 input logic [7:0] eg, input logic et);
        exp_t e;
        req       = r;
        done      = d;
        e.tag     = tag;
        e.gnt     = eg;
        e.idx     = idxOf(eg);
        e.valid   = |eg;
        e.timeout = et;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput({tag, ".queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput({e.tag, ".gnt"},       32'(gnt),       32'(e.gnt));
            checkOutput({e.tag, ".gnt_idx"},   32'(gnt_idx),   32'(e.idx));
            checkOutput({e.tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e.valid));
            checkOutput({e.tag, ".timeout"},   32'(timeout),   32'(e.timeout));
        end
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        @(posedge clk);
        #1;
        checkCleared(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #3;
        checkCleared("por");

        // Basic grant, done at the last hold cycle (done must beat timeout).
        doReset("t1_reset");
        applyStimulus("t1_idle",   8'h00, 1'b0, 8'h00, 1'b0);
        applyStimulus("t1_c1",     8'h04, 1'b0, 8'h04, 1'b0);
        applyStimulus("t1_c2",     8'h04, 1'b0, 8'h04, 1'b0);
        applyStimulus("t1_c3",     8'h04, 1'b0, 8'h04, 1'b0);
        applyStimulus("t1_c4",     8'h04, 1'b0, 8'h04, 1'b0);
        applyStimulus("t1_done",   8'h04, 1'b1, 8'h00, 1'b0);
        applyStimulus("t1_toidle", 8'h00, 1'b0, 8'h00, 1'b0);
        applyStimulus("t1_idle2",  8'h00, 1'b0, 8'h00, 1'b0);

        // Two requesters held; fixed mode always bit 7, rotating alternates.
        doReset("t2_reset");
        applyStimulus("t2_g1",   8'h81, 1'b0, 8'h80,    1'b0);
        applyStimulus("t2_d1",   8'h81, 1'b1, 8'h00,    1'b0);
        applyStimulus("t2_g2",   8'h81, 1'b0, ALT_GNT,  1'b0);
        applyStimulus("t2_d2",   8'h81, 1'b1, 8'h00,    1'b0);
        applyStimulus("t2_g3",   8'h81, 1'b0, 8'h80,    1'b0);
        applyStimulus("t2_d3",   8'h81, 1'b1, 8'h00,    1'b0);
        applyStimulus("t2_g4",   8'h81, 1'b0, ALT_GNT,  1'b0);
        applyStimulus("t2_end",  8'h00, 1'b1, 8'h00,    1'b0);
        applyStimulus("t2_idle", 8'h00, 1'b0, 8'h00,    1'b0);

        // Hold budget exhaustion and re-grant of the same requester.
        doReset("t4_reset");
        applyStimulus("t4_h0",     8'h08, 1'b0, 8'h08, 1'b0);
        applyStimulus("t4_h1",     8'h08, 1'b0, 8'h08, 1'b0);
        applyStimulus("t4_h2",     8'h08, 1'b0, 8'h08, 1'b0);
        applyStimulus("t4_h3",     8'h08, 1'b0, 8'h08, 1'b0);
        applyStimulus("t4_tmo",    8'h08, 1'b0, 8'h00, 1'b1);
        applyStimulus("t4_regnt",  8'h08, 1'b0, 8'h08, 1'b0);
        applyStimulus("t4_drop",   8'h00, 1'b0, 8'h00, 1'b0);
        applyStimulus("t4_idle",   8'h00, 1'b0, 8'h00, 1'b0);

        // No preemption, release on request drop, then done/timeout tie.
        doReset("t5_reset");
        applyStimulus("t5_g",      8'h20, 1'b0, 8'h20, 1'b0);
        applyStimulus("t5_nopre1", 8'hA0, 1'b0, 8'h20, 1'b0);
        applyStimulus("t5_nopre2", 8'hA0, 1'b0, 8'h20, 1'b0);
        applyStimulus("t5_drop",   8'h80, 1'b0, 8'h00, 1'b0);
        applyStimulus("t5_g7_h0",  8'h80, 1'b0, 8'h80, 1'b0);
        applyStimulus("t5_g7_h1",  8'h80, 1'b0, 8'h80, 1'b0);
        applyStimulus("t5_g7_h2",  8'h80, 1'b0, 8'h80, 1'b0);
        applyStimulus("t5_g7_h3",  8'h80, 1'b0, 8'h80, 1'b0);
        applyStimulus("t5_tie",    8'h80, 1'b1, 8'h00, 1'b0);
        applyStimulus("t5_idle",   8'h00, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a grant.
        doReset("t6_reset");
        applyStimulus("t6_g0", 8'h10, 1'b0, 8'h10, 1'b0);
        applyStimulus("t6_g1", 8'h10, 1'b0, 8'h10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("t6_async");
        @(posedge clk);
        #1;
        checkCleared("t6_held");
        #1;
        rst_n = 1'b1;
        applyStimulus("t6_first", 8'h10, 1'b0, 8'h10, 1'b0);
        applyStimulus("t6_drop",  8'h00, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset during the timeout pulse cycle.
        doReset("t6b_reset");
        applyStimulus("t6b_h0",  8'h10, 1'b0, 8'h10, 1'b0);
        applyStimulus("t6b_h1",  8'h10, 1'b0, 8'h10, 1'b0);
        applyStimulus("t6b_h2",  8'h10, 1'b0, 8'h10, 1'b0);
        applyStimulus("t6b_h3",  8'h10, 1'b0, 8'h10, 1'b0);
        applyStimulus("t6b_tmo", 8'h10, 1'b0, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("t6b_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("t6b_first", 8'h10, 1'b0, 8'h10, 1'b0);
        applyStimulus("t6b_end",   8'h00, 1'b1, 8'h00, 1'b0);
        applyStimulus("t6b_idle",  8'h00, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
